// File: rtl/branch_ctrl_if.sv
// ID-stage branch request bundle and redirect/stall responses.
// master = ID stage driving the branch, slave = branch_ctrl.
interface branch_ctrl_if;
  logic        id_valid;
  logic [2:0]  id_br_op;
  logic [31:0] id_pc4;
  logic [15:0] id_imm16;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_rdy;
  logic        rt_rdy;
  logic        stall_out;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush_if;

  modport master (
    output id_valid, id_br_op, id_pc4, id_imm16,
    output rs_val, rt_val, rs_rdy, rt_rdy,
    input  stall_out, br_taken, br_target, flush_if
  );

  modport slave (
    input  id_valid, id_br_op, id_pc4, id_imm16,
    input  rs_val, rt_val, rs_rdy, rt_rdy,
    output stall_out, br_taken, br_target, flush_if
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution in ID: evaluates condition, stalls on unready
// operands, issues a one-cycle registered PC redirect.
// Ports: clk, rst (sync, active-high), bus (branch_ctrl_if.slave):
//   id_* / rs_* / rt_* in; stall_out, br_taken, br_target, flush_if out.
// Macro BRANCH_DELAY_SLOT_EN: delay slot executes, flush_if tied 0.
module branch_ctrl (
  input  logic         clk,
  input  logic         rst,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e      state_q;
  logic        taken_q;
  logic [31:0] tgt_q;

  logic        is_br;
  logic        need_rt;
  logic        ops_rdy;
  logic        cond;
  logic [31:0] tgt_d;
  logic        rs_neg;
  logic        rs_zero;

  // 111 is reserved and behaves like "no branch"
  assign is_br   = bus.id_valid
                && (bus.id_br_op != 3'b000)
                && (bus.id_br_op != 3'b111);
  assign need_rt = (bus.id_br_op == 3'b001)
                || (bus.id_br_op == 3'b010);
  assign ops_rdy = bus.rs_rdy && (!need_rt || bus.rt_rdy);

  assign rs_neg  = bus.rs_val[31];
  assign rs_zero = (bus.rs_val == 32'd0);

  always_comb begin
    cond = 1'b0;
    case (bus.id_br_op)
      3'b001:  cond = (bus.rs_val == bus.rt_val);
      3'b010:  cond = (bus.rs_val != bus.rt_val);
      3'b011:  cond = !rs_neg;
      3'b100:  cond = !rs_neg && !rs_zero;
      3'b101:  cond = rs_neg || rs_zero;
      3'b110:  cond = rs_neg;
      default: cond = 1'b0;
    endcase
  end

  assign tgt_d = bus.id_pc4
               + {{14{bus.id_imm16[15]}}, bus.id_imm16, 2'b00};

  // Combinational so the PC/IFID hold takes effect the same cycle
  assign bus.stall_out = !rst && is_br && !ops_rdy
                      && (state_q != REDIR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      tgt_q   <= 32'd0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_br && ops_rdy && cond) begin
            tgt_q   <= tgt_d;
            taken_q <= 1'b1;
            state_q <= REDIR;
          end else if (is_br && !ops_rdy) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!is_br) begin
            state_q <= IDLE;
          end else if (ops_rdy) begin
            if (cond) begin
              tgt_q   <= tgt_d;
              taken_q <= 1'b1;
              state_q <= REDIR;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        REDIR: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.br_taken  = taken_q;
  assign bus.br_target = tgt_q;

`ifdef BRANCH_DELAY_SLOT_EN
  assign bus.flush_if = 1'b0;
`else
  assign bus.flush_if = taken_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: expected redirects queued at
// drive time, popped and compared when the cycle comes due.
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_ctrl_if bus ();

  branch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit rst_edge = 1'b0;
  bit mon_en   = 1'b0;
  logic [31:0] last_tgt = 32'd0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] tgt_of(input logic [31:0] pc4,
                                         input logic [15:0] imm);
    logic [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc4 + off;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // Redirect monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_edge) last_tgt = 32'd0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("br_taken", {31'd0, bus.br_taken}, 32'd1);
        chk("br_target", bus.br_target, e.tgt);
`ifdef BRANCH_DELAY_SLOT_EN
        chk("flush_if", {31'd0, bus.flush_if}, 32'd0);
`else
        chk("flush_if", {31'd0, bus.flush_if}, 32'd1);
`endif
        last_tgt = e.tgt;
      end else begin
        chk("no_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("no_flush", {31'd0, bus.flush_if}, 32'd0);
        chk("hold_tgt", bus.br_target, last_tgt);
      end
    end
  end

  // One cycle of stimulus; tk=1 queues a redirect for next cycle
  task automatic drv(input string tag,
                     input logic v, input logic [2:0] op,
                     input logic [31:0] pc4, input logic [15:0] imm,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic rsr, input logic rtr,
                     input logic r, input logic st,
                     input logic tk);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.id_valid = v;
    bus.id_br_op = op;
    bus.id_pc4   = pc4;
    bus.id_imm16 = imm;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.rs_rdy   = rsr;
    bus.rt_rdy   = rtr;
    if (tk) begin
      e.cyc = cyc + 1;
      e.tgt = tgt_of(pc4, imm);
      q.push_back(e);
    end
    #3;
    chk({tag, "_stall"}, {31'd0, bus.stall_out}, {31'd0, st});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drv("idle", 1'b0, 3'b000, 32'd0, 16'd0, 32'd0, 32'd0,
          1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.id_valid = 1'b0;
    bus.id_br_op = 3'b000;
    bus.id_pc4   = 32'd0;
    bus.id_imm16 = 16'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.rs_rdy   = 1'b1;
    bus.rt_rdy   = 1'b1;

    // reset with a stalling branch present: stall must stay low
    drv("rst0", 1'b1, 3'b011, 32'd0, 16'd0, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drv("rst1", 1'b1, 3'b011, 32'd0, 16'd0, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mon_en = 1'b1;
    idle(2);

    chk("tgt_fn", tgt_of(32'h0040_0010, 16'h0004), 32'h0040_0020);

    // BEQ 5==5 taken
    drv("beq", 1'b1, 3'b001, 32'h0040_0010, 16'h0004, 32'd5, 32'd5,
        1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);

    // BNE 7,7 not taken
    drv("bne", 1'b1, 3'b010, 32'h0000_1000, 16'h0010, 32'd7, 32'd7,
        1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // BGEZ waits two cycles for rs, then rs=0 -> taken
    drv("bgez_w0", 1'b1, 3'b011, 32'h0000_2000, 16'h0020, 32'd0,
        32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drv("bgez_w1", 1'b1, 3'b011, 32'h0000_2000, 16'h0020, 32'd0,
        32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drv("bgez_rdy", 1'b1, 3'b011, 32'h0000_2000, 16'h0020, 32'd0,
        32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);

    // BLTZ negative offset with wrap-around
    chk("tgt_wrap", tgt_of(32'h0000_0004, 16'hFFFE), 32'hFFFF_FFFC);
    drv("bltz", 1'b1, 3'b110, 32'h0000_0004, 16'hFFFE, 32'hFFFF_FFFF,
        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // signed zero-compare corners
    drv("bgtz0", 1'b1, 3'b100, 32'h100, 16'h1, 32'd0, 32'd0,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv("bgtz1", 1'b1, 3'b100, 32'h100, 16'h2, 32'd1, 32'd0,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    drv("blez_min", 1'b1, 3'b101, 32'h200, 16'h8, 32'h8000_0000,
        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    drv("blez_pos", 1'b1, 3'b101, 32'h200, 16'h8, 32'h7FFF_FFFF,
        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv("bltz0", 1'b1, 3'b110, 32'h300, 16'h8, 32'd0, 32'd0,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv("bgez_neg", 1'b1, 3'b011, 32'h300, 16'h8, 32'hFFFF_FFFF,
        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // BEQ waits on rt only, resolves not-taken -> back to IDLE
    drv("beq_rt_w", 1'b1, 3'b001, 32'h400, 16'h4, 32'd3, 32'd4,
        1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drv("beq_rt_r", 1'b1, 3'b001, 32'h400, 16'h4, 32'd3, 32'd4,
        1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // reserved op and id_valid=0 never stall or branch
    drv("rsvd", 1'b1, 3'b111, 32'h500, 16'h4, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv("novalid", 1'b0, 3'b001, 32'h500, 16'h4, 32'd1, 32'd1,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // branch in REDIR cycle is ignored, even when operands unready
    drv("beq_a", 1'b1, 3'b001, 32'h600, 16'h10, 32'd9, 32'd9,
        1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drv("redir_ign", 1'b1, 3'b010, 32'h700, 16'h20, 32'd1, 32'd2,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // reset while in WAIT: stall drops, no later redirect
    drv("wait_a", 1'b1, 3'b011, 32'h800, 16'h4, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drv("wait_rst", 1'b1, 3'b011, 32'h800, 16'h4, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // reset while in REDIR: target cleared next cycle
    drv("redir_a", 1'b1, 3'b110, 32'h900, 16'h4, 32'hFFFF_FFF0,
        32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drv("redir_rst", 1'b0, 3'b000, 32'd0, 16'd0, 32'd0, 32'd0,
        1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // reset in the resolving cycle discards the redirect
    drv("res_rst", 1'b1, 3'b001, 32'hA00, 16'h4, 32'd2, 32'd2,
        1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    chk("q_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The module SHALL use one clock and a reset that is synchronous and active-high; clk and rst are the clock and reset ports.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port id_valid  input  1  ID-stage instruction valid.
REQ-005 Port id_br_op  input  3  branch type: 000 none, 001 BEQ, 010 BNE, 011 BGEZ, 100 BGTZ, 101 BLEZ, 110 BLTZ, 111 reserved (treated as none).
REQ-006 Port id_pc4  input  32  PC+4 of the ID-stage instruction.
REQ-007 Port id_imm16  input  16  raw branch offset field.
REQ-008 Port rs_val, rt_val  input  32 each  forwarded operand values.
REQ-009 Port rs_rdy, rt_rdy  input  1 each  operand valid (no pending load producer).
REQ-010 Port stall_out  output  1  hold PC and IF/ID register.
REQ-011 Port br_taken  output  1  redirect PC this cycle.
REQ-012 Port br_target  output  32  redirect address.
REQ-013 Port flush_if  output  1  squash the instruction in IF/ID.

Function
REQ-014 States SHALL be IDLE, WAIT, REDIR.
REQ-015 A branch is present when id_valid=1 and id_br_op is in 001..110.
REQ-016 BEQ/BNE SHALL require rs_rdy and rt_rdy; all other branch types SHALL require rs_rdy only.
REQ-017 Conditions SHALL be: BEQ rs==rt; BNE rs!=rt; BGEZ rs>=0; BGTZ rs>0; BLEZ rs<=0; BLTZ rs<0. All comparisons against zero are signed.
REQ-018 Target SHALL be id_pc4 + {14 copies of id_imm16[15], id_imm16, 2'b00}, computed modulo 2^32 (wrap-around, no carry out).
REQ-019 IDLE with a branch and operands ready: evaluate the condition. If taken, latch the target and go to REDIR; if not taken, stay in IDLE. No stall is asserted.
REQ-020 IDLE with a branch and operands not ready: assert stall_out combinationally in the same cycle and go to WAIT.
REQ-021 WAIT SHALL assert stall_out. When the operands become ready, evaluate as in REQ-019 (taken goes to REDIR, not taken goes to IDLE) and deassert stall_out in that cycle. ID inputs are held stable by the stall.
REQ-022 REDIR SHALL assert br_taken=1 for exactly one cycle with br_target equal to the latched target, with stall_out=0, then return to IDLE.
REQ-023 Latency: a taken branch resolved in cycle N SHALL produce br_taken in cycle N+1 (registered).
REQ-024 A branch present in ID while in REDIR SHALL be ignored.
REQ-025 br_target SHALL hold its last latched value outside REDIR.
REQ-026 A not-taken branch SHALL never assert br_taken or flush_if.

Reset
REQ-027 With rst=1 at a rising edge, state SHALL become IDLE and br_taken, flush_if and br_target SHALL become 0.
REQ-028 stall_out SHALL be 0 whenever rst=1.
REQ-029 Reset SHALL take priority over all transitions, including mid-WAIT and mid-REDIR; a pending redirect is discarded.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN: when defined, flush_if SHALL stay 0 at all times and the delay-slot instruction executes.
REQ-031 When BRANCH_DELAY_SLOT_EN is undefined, flush_if SHALL equal br_taken, squashing the IF/ID instruction in the REDIR cycle.

Verification
REQ-032 BEQ with rs=rt=5, both ready, pc4=0x00400010, imm=0x0004 -> next cycle br_taken=1, br_target=0x00400020, stall_out=0 throughout.
REQ-033 BNE with rs=rt=7 -> br_taken stays 0, state stays IDLE, no stall.
REQ-034 BGEZ with rs_rdy=0 for 2 cycles, then rs=0 ready -> stall_out=1 for 2 cycles; br_taken one cycle after ready with target pc4+offset.
REQ-035 BLTZ with rs=0xFFFFFFFF, pc4=0x00000004, imm=0xFFFE -> br_target=0xFFFFFFFC (negative offset, wrap-around); flush_if=1 only when the macro is undefined.
REQ-036 rst=1 asserted while in WAIT and while in REDIR -> next cycle all outputs 0, state IDLE, no later redirect.
